// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the 2 KB system RAM between the screen fetcher, the program loader and the 6502.
// Screen and loader always win; the CPU is paused through RDY and its last read is replayed before resume.
module ram_arbiter #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  scr_req,
  input  logic [ADDR_WIDTH-1:0] scr_addr,
  output logic                  scr_rvalid,
  input  logic                  ldr_req,
  input  logic                  ldr_we,
  input  logic [ADDR_WIDTH-1:0] ldr_addr,
  input  logic [DATA_WIDTH-1:0] ldr_wdata,
  input  logic [15:0]           cpu_addr,
  input  logic                  cpu_we,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_rdy,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_we
);

  typedef enum logic [1:0] {
    RUN,
    HOLD,
    RESTORE
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] last_addr;
  logic [ADDR_WIDTH-1:0] cpu_addr_lo;
  logic                  any_req;
  logic                  unused_cpu_addr_hi;

  // Upper CPU address bits are dropped so the RAM image mirrors across the 64 KB space.
  assign cpu_addr_lo        = cpu_addr[ADDR_WIDTH-1:0];
  assign unused_cpu_addr_hi = ^cpu_addr[15:ADDR_WIDTH];
  assign any_req            = scr_req | ldr_req;
  assign cpu_rdy            = (state == RUN) && !any_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= HOLD;
      last_addr  <= '0;
      scr_rvalid <= 1'b0;
    end else begin
      scr_rvalid <= scr_req;
      if (cpu_rdy) begin
        last_addr <= cpu_addr_lo;
      end
      case (state)
        RUN:     if (any_req) state <= HOLD;
        HOLD:    if (!any_req) state <= RESTORE;
        RESTORE: state <= any_req ? HOLD : RUN;
        default: state <= HOLD;
      endcase
    end
  end

  // RESTORE and HOLD both present last_addr so the stalled CPU finds its data on resume.
  always_comb begin
    ram_raddr = last_addr;
    if (scr_req) begin
      ram_raddr = scr_addr;
    end else if (state == RUN) begin
      ram_raddr = cpu_addr_lo;
    end
  end

  always_comb begin
    ram_waddr = cpu_addr_lo;
    ram_wdata = cpu_wdata;
    ram_we    = cpu_we && cpu_rdy;
    if (ldr_req) begin
      ram_waddr = ldr_addr;
      ram_wdata = ldr_wdata;
      ram_we    = ldr_we;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed vectors against a block-RAM model, with a scoreboard queue
// for screen read data checked by an independent monitor.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        scr_req;
  logic [10:0] scr_addr;
  logic        scr_rvalid;
  logic        ldr_req;
  logic        ldr_we;
  logic [10:0] ldr_addr;
  logic [7:0]  ldr_wdata;
  logic [15:0] cpu_addr;
  logic        cpu_we;
  logic [7:0]  cpu_wdata;
  logic        cpu_rdy;
  logic [10:0] ram_raddr;
  logic [10:0] ram_waddr;
  logic [7:0]  ram_wdata;
  logic        ram_we;

  logic [7:0]  ram [0:2047];
  logic [7:0]  ram_rdata = 8'h00;
  logic [7:0]  scr_exp_q [$];
  logic [7:0]  scr_exp_now;
  int          assert_count = 0;
  int          fail_count = 0;

  ram_arbiter #(.ADDR_WIDTH(11), .DATA_WIDTH(8)) dut (
    .clk(clk), .reset(reset),
    .scr_req(scr_req), .scr_addr(scr_addr), .scr_rvalid(scr_rvalid),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata), .cpu_rdy(cpu_rdy),
    .ram_raddr(ram_raddr), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .ram_we(ram_we)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM with independent read and write ports.
  always @(posedge clk) begin
    if (ram_we) ram[ram_waddr] <= ram_wdata;
    ram_rdata <= ram[ram_raddr];
  end

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic s_req, input logic [10:0] s_addr, input logic [7:0] s_exp,
                               input logic l_req, input logic l_we, input logic [10:0] l_addr,
                               input logic [7:0] l_wdata, input logic [15:0] c_addr,
                               input logic c_we, input logic [7:0] c_wdata);
    @(negedge clk);
    scr_req   = s_req;
    scr_addr  = s_addr;
    ldr_req   = l_req;
    ldr_we    = l_we;
    ldr_addr  = l_addr;
    ldr_wdata = l_wdata;
    cpu_addr  = c_addr;
    cpu_we    = c_we;
    cpu_wdata = c_wdata;
    if (s_req) scr_exp_q.push_back(s_exp);
    #1;
  endtask

  task automatic cpuCycle(input logic [15:0] c_addr, input logic c_we, input logic [7:0] c_wdata);
    applyStimulus(1'b0, 11'h000, 8'h00, 1'b0, 1'b0, 11'h000, 8'h00, c_addr, c_we, c_wdata);
  endtask

  // Screen monitor: every scr_rvalid must match the oldest outstanding screen request.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (scr_rvalid === 1'b1) begin
        if (scr_exp_q.size() == 0) begin
          assert_count++;
          fail_count++;
          $display("[TB] FAIL scr_unexpected: got rvalid=1 data 0x%0h, expected no screen data", ram_rdata);
        end else begin
          scr_exp_now = scr_exp_q.pop_front();
          checkOutput("scr_rdata", {8'h00, ram_rdata}, {8'h00, scr_exp_now});
        end
      end
    end
  end

  initial begin
    #200000;
    fail_count++;
    $display("[TB] FAIL watchdog: got timeout, expected end of stimulus");
    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

  initial begin
    for (int i = 0; i < 2048; i++) ram[i] = 8'h00;
    ram[11'h200] = 8'h5A;
    ram[11'h123] = 8'hC3;
    ram[11'h100] = 8'h3C;
    ram[11'h010] = 8'h11;
    reset = 1'b1;
    scr_req = 1'b0; scr_addr = '0; ldr_req = 1'b0; ldr_we = 1'b0; ldr_addr = '0;
    ldr_wdata = '0; cpu_addr = '0; cpu_we = 1'b0; cpu_wdata = '0;

    // Reset release
    repeat (4) @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("reset_cpu_rdy", 16'(cpu_rdy), 16'h0);
    checkOutput("reset_scr_rvalid", 16'(scr_rvalid), 16'h0);
    checkOutput("reset_raddr", 16'(ram_raddr), 16'h0);
    reset = 1'b0;
    cpuCycle(16'h0200, 1'b0, 8'h00);
    checkOutput("restore_cpu_rdy", 16'(cpu_rdy), 16'h0);
    checkOutput("restore_raddr", 16'(ram_raddr), 16'h0);
    cpuCycle(16'h0200, 1'b0, 8'h00);
    checkOutput("run_cpu_rdy", 16'(cpu_rdy), 16'h1);
    checkOutput("run_raddr", 16'(ram_raddr), 16'h0200);

    // Screen stall
    applyStimulus(1'b1, 11'h123, 8'hC3, 1'b0, 1'b0, 11'h000, 8'h00, 16'h0200, 1'b0, 8'h00);
    checkOutput("stall_cpu_rdy", 16'(cpu_rdy), 16'h0);
    checkOutput("stall_raddr", 16'(ram_raddr), 16'h0123);
    checkOutput("stall_cpu_rdata", {8'h00, ram_rdata}, 16'h005A);
    cpuCycle(16'h0200, 1'b0, 8'h00);
    checkOutput("hold_cpu_rdy", 16'(cpu_rdy), 16'h0);
    checkOutput("hold_raddr", 16'(ram_raddr), 16'h0200);
    cpuCycle(16'h0200, 1'b0, 8'h00);
    checkOutput("restore2_cpu_rdy", 16'(cpu_rdy), 16'h0);
    checkOutput("restore2_raddr", 16'(ram_raddr), 16'h0200);
    cpuCycle(16'h0200, 1'b0, 8'h00);
    checkOutput("resume_cpu_rdy", 16'(cpu_rdy), 16'h1);
    checkOutput("resume_rdata", {8'h00, ram_rdata}, 16'h005A);

    // Blocked CPU write
    applyStimulus(1'b1, 11'h123, 8'hC3, 1'b0, 1'b0, 11'h000, 8'h00, 16'h0010, 1'b1, 8'h77);
    checkOutput("blk_cpu_rdy", 16'(cpu_rdy), 16'h0);
    checkOutput("blk_we_stall", 16'(ram_we), 16'h0);
    cpuCycle(16'h0010, 1'b1, 8'h77);
    checkOutput("blk_we_hold", 16'(ram_we), 16'h0);
    cpuCycle(16'h0010, 1'b1, 8'h77);
    checkOutput("blk_we_restore", 16'(ram_we), 16'h0);
    checkOutput("blk_mem_unchanged", {8'h00, ram[11'h010]}, 16'h0011);
    cpuCycle(16'h0010, 1'b1, 8'h77);
    checkOutput("blk_we_run", 16'(ram_we), 16'h1);
    checkOutput("blk_waddr_run", 16'(ram_waddr), 16'h0010);
    cpuCycle(16'h0010, 1'b0, 8'h00);
    checkOutput("blk_we_once", 16'(ram_we), 16'h0);
    checkOutput("blk_mem_written", {8'h00, ram[11'h010]}, 16'h0077);
    cpuCycle(16'h0010, 1'b0, 8'h00);
    checkOutput("blk_readback", {8'h00, ram_rdata}, 16'h0077);

    // Loader plus screen
    for (int i = 0; i < 16; i++) begin
      applyStimulus((i % 2) == 0, 11'h100, 8'h3C, 1'b1, 1'b1, 11'(32'h600 + i), 8'(i),
                    16'h0010, 1'b0, 8'h00);
      checkOutput("ldr_cpu_rdy", 16'(cpu_rdy), 16'h0);
      checkOutput("ldr_we", 16'(ram_we), 16'h1);
      checkOutput("ldr_waddr", 16'(ram_waddr), 16'(32'h600 + i));
    end
    applyStimulus(1'b0, 11'h000, 8'h00, 1'b1, 1'b0, 11'h000, 8'h00, 16'h0010, 1'b0, 8'h00);
    checkOutput("ldr_idle_we", 16'(ram_we), 16'h0);
    checkOutput("ldr_idle_cpu_rdy", 16'(cpu_rdy), 16'h0);
    for (int i = 0; i < 16; i++) begin
      checkOutput("ldr_mem", {8'h00, ram[11'(32'h600 + i)]}, 16'(i));
    end

    // Cancelled resume
    cpuCycle(16'h0010, 1'b0, 8'h00);
    checkOutput("cancel_hold_rdy", 16'(cpu_rdy), 16'h0);
    applyStimulus(1'b1, 11'h100, 8'h3C, 1'b0, 1'b0, 11'h000, 8'h00, 16'h0010, 1'b0, 8'h00);
    checkOutput("cancel_restore_rdy", 16'(cpu_rdy), 16'h0);
    checkOutput("cancel_restore_raddr", 16'(ram_raddr), 16'h0100);
    cpuCycle(16'h0010, 1'b0, 8'h00);
    checkOutput("cancel_back_hold_rdy", 16'(cpu_rdy), 16'h0);
    checkOutput("cancel_back_hold_raddr", 16'(ram_raddr), 16'h0010);
    cpuCycle(16'h0010, 1'b0, 8'h00);
    checkOutput("cancel_restore2_rdy", 16'(cpu_rdy), 16'h0);
    cpuCycle(16'h0010, 1'b0, 8'h00);
    checkOutput("cancel_resume_rdy", 16'(cpu_rdy), 16'h1);
    checkOutput("cancel_resume_rdata", {8'h00, ram_rdata}, 16'h0077);

    // Aliasing
    cpuCycle(16'h0812, 1'b1, 8'hAB);
    checkOutput("alias_we", 16'(ram_we), 16'h1);
    checkOutput("alias_waddr", 16'(ram_waddr), 16'h0012);
    cpuCycle(16'h0012, 1'b0, 8'h00);
    checkOutput("alias_raddr", 16'(ram_raddr), 16'h0012);
    cpuCycle(16'h0012, 1'b0, 8'h00);
    checkOutput("alias_rdata", {8'h00, ram_rdata}, 16'h00AB);

    // Reset mid-operation while the loader keeps writing
    reset = 1'b1;
    cpuCycle(16'h0012, 1'b0, 8'h00);
    checkOutput("midrst_cpu_rdy", 16'(cpu_rdy), 16'h0);
    applyStimulus(1'b0, 11'h000, 8'h00, 1'b1, 1'b1, 11'h700, 8'h99, 16'h0012, 1'b0, 8'h00);
    checkOutput("midrst_ldr_we", 16'(ram_we), 16'h1);
    checkOutput("midrst_ldr_waddr", 16'(ram_waddr), 16'h0700);
    reset = 1'b0;
    cpuCycle(16'h0012, 1'b0, 8'h00);
    checkOutput("midrst_hold_rdy", 16'(cpu_rdy), 16'h0);
    cpuCycle(16'h0012, 1'b0, 8'h00);
    checkOutput("midrst_restore_rdy", 16'(cpu_rdy), 16'h0);
    checkOutput("midrst_restore_raddr", 16'(ram_raddr), 16'h0000);
    cpuCycle(16'h0012, 1'b0, 8'h00);
    checkOutput("midrst_resume_rdy", 16'(cpu_rdy), 16'h1);
    checkOutput("midrst_ldr_mem", {8'h00, ram[11'h700]}, 16'h0099);

    repeat (2) @(negedge clk);
    checkOutput("scr_queue_empty", 16'(scr_exp_q.size()), 16'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Arbiter for the shared 2 KB system RAM (synchronous-read block RAM with separate read and write ports) between the VGA screen fetcher, the UART program loader and the 6502 core. Screen and loader requests always win immediately. The CPU is stalled through its RDY input. Before RDY is re-asserted, the block re-issues the CPU's last read address for one cycle, so the core sees correct DI on resume. It replaces the ad-hoc ready / before-ready logic and address muxes in the top level.

## Interface
Parameters:
- ADDR_WIDTH, 11, RAM address width.
- DATA_WIDTH, 8, RAM data width.

Ports:
- clk  in  1  system clock (25.125 MHz pixel clock).
- reset  in  1  synchronous, active-high.
- scr_req  in  1  screen wants the read port this cycle (level).
- scr_addr  in  ADDR_WIDTH  screen read address.
- scr_rvalid  out  1  ram_rdata holds the data for the previous cycle's scr_addr.
- ldr_req  in  1  loader owns the write port (level, held for the whole transfer).
- ldr_we  in  1  loader write strobe.
- ldr_addr  in  ADDR_WIDTH  loader write address.
- ldr_wdata  in  DATA_WIDTH  loader write data.
- cpu_addr  in  16  CPU address bus (combinatorial AB).
- cpu_we  in  1  CPU write enable.
- cpu_wdata  in  DATA_WIDTH  CPU write data.
- cpu_rdy  out  1  CPU RDY; 0 pauses the core.
- ram_raddr  out  ADDR_WIDTH  RAM read address.
- ram_waddr  out  ADDR_WIDTH  RAM write address.
- ram_wdata  out  DATA_WIDTH  RAM write data.
- ram_we  out  1  RAM write enable.

## Operation
- The FSM has three states:
  - RUN: CPU owns both ports.
  - HOLD: CPU stalled.
  - RESTORE: re-read the CPU's last address.
- Transitions:
  - Reset → HOLD.
  - RUN → HOLD when scr_req or ldr_req is high.
  - HOLD → RESTORE when both are low, else stay in HOLD.
  - RESTORE → HOLD when either is high, else RUN.
- cpu_rdy = (state==RUN) && !scr_req && !ldr_req. It is combinational, so a request stalls the CPU in the same cycle it appears.
- Read-port mux, in priority order:
  - scr_req → scr_addr.
  - Else state==RUN → cpu_addr[ADDR_WIDTH-1:0].
  - Else → last_addr.
- Write-port mux:
  - If ldr_req: ram_waddr/ram_wdata = ldr_addr/ldr_wdata and ram_we = ldr_we.
  - Else: ram_waddr/ram_wdata = cpu_addr[ADDR_WIDTH-1:0]/cpu_wdata and ram_we = cpu_we && cpu_rdy.
- Screen reads and loader writes may proceed in the same cycle, since they use independent ports.
- last_addr register: loads cpu_addr[ADDR_WIDTH-1:0] on every cycle with cpu_rdy=1, holds otherwise. It resets to 0.
- Address aliasing: cpu_addr bits above ADDR_WIDTH are ignored, so the RAM image mirrors every 2^ADDR_WIDTH bytes.
- A CPU write is never performed while cpu_rdy=0, even if cpu_we=1.

## Timing
- Reset values: state=HOLD, last_addr=0, scr_rvalid=0, cpu_rdy=0.
  - The combinational outputs follow the muxes above with state=HOLD.
- scr_rvalid = scr_req registered one cycle; RAM read latency is 1.
  - A screen request at cycle t yields data plus scr_rvalid=1 at t+1.
  - No screen request is ever dropped or delayed.
- Resume latency:
  - If requests are low from cycle t (state HOLD), cycle t is still HOLD and t+1 is RESTORE (ram_raddr=last_addr).
  - cpu_rdy=1 at t+2, with ram_rdata equal to mem[last_addr].
- A request during RESTORE cancels the resume: back to HOLD, and the 2-cycle resume restarts once requests drop.
- A single-cycle scr_req pulse during RUN costs the CPU 3 cycles: the stall cycle, HOLD, RESTORE.
- Reset asserted mid-operation forces HOLD next cycle regardless of requests. A loader transfer in progress continues on the write port, because the write mux is combinational on ldr_req.

## Test plan
- **Reset release:** reset high for 4 cycles, then low with no requests.
  - Expect cpu_rdy=0 for 2 cycles, then 1.
  - Expect ram_raddr=0 during the RESTORE cycle.
- **Screen stall:** CPU reads 0x0200 in RUN (mem=0x5A); scr_req=1 for 1 cycle with scr_addr=0x123 (mem=0xC3).
  - Expect cpu_rdy=0 that same cycle.
  - Expect ram_rdata=0xC3 with scr_rvalid=1 the next cycle.
  - Expect RESTORE to read 0x200, then cpu_rdy=1 with ram_rdata=0x5A.
- **Blocked CPU write:** cpu_we=1, cpu_addr=0x0010, cpu_wdata=0x77 while scr_req=1.
  - Expect ram_we=0 and mem[0x10] unchanged.
  - After resume the same write lands, with ram_we=1 for exactly one cycle.
- **Loader plus screen:** ldr_req=1 with ldr_we pulses writing 0x00..0x0F to 0x600..0x60F, while scr_req pulses read 0x100.
  - Expect all 16 writes committed, every screen read valid, and cpu_rdy=0 throughout.
- **Cancelled resume:** drop both requests, then assert scr_req during the RESTORE cycle.
  - Expect the FSM back in HOLD and cpu_rdy staying 0.
  - After release, cpu_rdy rises exactly 2 cycles later.
- **Aliasing:** CPU write 0xAB to cpu_addr=0x0812, then read 0x0012 → 0xAB.
